// File: rtl/ldpc_layer_scheduler_pkg.sv
// Shared types and width helpers for the LDPC layer scheduler and the CNU control unit.
package ldpc_layer_scheduler_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StStart   = 3'd1,
    StLayer   = 3'd2,
    StWbWait  = 3'd3,
    StIterChk = 3'd4,
    StTerm    = 3'd5
  } sched_state_e;

  localparam int unsigned LayerNumDefault = 3;
  localparam int unsigned MaxIterDefault  = 10;

  // Layer index width; kept at least 1 bit so a degenerate LAYER_NUM still elaborates.
  function automatic int unsigned layer_bits(input int unsigned layer_num);
    return (layer_num > 1) ? $clog2(layer_num) : 1;
  endfunction

  // Iteration index must hold the value MAX_ITER itself.
  function automatic int unsigned iter_bits(input int unsigned max_iter);
    return $clog2(max_iter + 1);
  endfunction

endpackage

// File: rtl/sched_wb_delay.sv
// Loadable down-counter: done_o is high in the cycle the count is about to reach zero.
module sched_wb_delay #(
  parameter int unsigned WB_LATENCY = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  output logic done_o
);

  localparam int unsigned CntW = $clog2(WB_LATENCY + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CntW'(WB_LATENCY);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == CntW'(1));

endmodule

// File: rtl/ldpc_layer_scheduler.sv
// Layer/iteration sequencer around the CNU control FSM.
// Define EARLY_TERM_EN to retire frames early on a zero syndrome.
module ldpc_layer_scheduler
  import ldpc_layer_scheduler_pkg::*;
#(
  parameter int unsigned LAYER_NUM  = LayerNumDefault,
  parameter int unsigned MAX_ITER   = MaxIterDefault,
  parameter int unsigned WB_LATENCY = 2,
  parameter int unsigned LAYER_BITS = layer_bits(LAYER_NUM),
  parameter int unsigned ITER_BITS  = iter_bits(MAX_ITER)
) (
  input  logic                  read_clk,
  input  logic                  rstn,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  output logic                  fsm_en,
  input  logic                  de_frame_start,
  input  logic                  c2v_mem_we,
  output logic                  layer_finish,
  output logic                  termination,
  output logic [LAYER_BITS-1:0] layer_idx,
  output logic [ITER_BITS-1:0]  iter_idx,
  input  logic                  syndrome_valid,
  input  logic                  syndrome_zero,
  output logic                  frame_done,
  output logic                  early_term,
  output logic                  proto_err
);

  localparam logic [LAYER_BITS-1:0] LastLayer = LAYER_BITS'(LAYER_NUM - 1);
  localparam logic [ITER_BITS-1:0]  MaxIterW  = ITER_BITS'(MAX_ITER);

  sched_state_e          state_q;
  logic                  fsm_en_q, layer_finish_q, termination_q, frame_done_q, proto_err_q;
  logic [LAYER_BITS-1:0] layer_q;
  logic [ITER_BITS-1:0]  iter_q;
  logic [ITER_BITS-1:0]  iter_nxt;
  logic                  accept, wb_load, wb_done, synd_stop, term_now, early_term_q;

  assign frame_ready = (state_q == StIdle);
  assign accept      = frame_ready && frame_valid;
  assign wb_load     = (state_q == StLayer) && c2v_mem_we;
  assign iter_nxt    = iter_q + ITER_BITS'(1);
  assign term_now    = (state_q == StIterChk) && ((iter_nxt == MaxIterW) || synd_stop);

  sched_wb_delay #(
    .WB_LATENCY (WB_LATENCY)
  ) u_wb_delay (
    .clk_i  (read_clk),
    .rst_ni (rstn),
    .load_i (wb_load),
    .done_o (wb_done)
  );

`ifdef EARLY_TERM_EN
  logic synd_q;

  // A strobe landing in the check cycle itself still counts for this iteration.
  assign synd_stop = synd_q || (syndrome_valid && syndrome_zero);

  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      synd_q       <= 1'b0;
      early_term_q <= 1'b0;
    end else begin
      if (accept || ((state_q == StIterChk) && !term_now)) begin
        synd_q <= 1'b0;
      end else if (syndrome_valid && syndrome_zero) begin
        synd_q <= 1'b1;
      end
      if (accept) begin
        early_term_q <= 1'b0;
      end else if (term_now && (iter_nxt != MaxIterW)) begin
        early_term_q <= 1'b1;
      end
    end
  end
`else
  logic unused_synd;

  assign unused_synd  = syndrome_valid & syndrome_zero;
  assign synd_stop    = 1'b0;
  assign early_term_q = 1'b0;
`endif

  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= StIdle;
      fsm_en_q       <= 1'b0;
      layer_finish_q <= 1'b0;
      termination_q  <= 1'b0;
      frame_done_q   <= 1'b0;
      proto_err_q    <= 1'b0;
      layer_q        <= '0;
      iter_q         <= '0;
    end else begin
      layer_finish_q <= 1'b0;
      frame_done_q   <= 1'b0;
      if (c2v_mem_we && (state_q != StLayer)) begin
        proto_err_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (frame_valid) begin
            layer_q  <= '0;
            iter_q   <= '0;
            fsm_en_q <= 1'b1;
            state_q  <= StStart;
          end
        end
        StStart: begin
          if (de_frame_start) begin
            state_q <= StLayer;
          end
        end
        StLayer: begin
          if (c2v_mem_we) begin
            state_q <= StWbWait;
          end
        end
        StWbWait: begin
          if (wb_done) begin
            layer_finish_q <= 1'b1;
            if (layer_q == LastLayer) begin
              state_q <= StIterChk;
            end else begin
              layer_q <= layer_q + LAYER_BITS'(1);
              state_q <= StLayer;
            end
          end
        end
        StIterChk: begin
          layer_q <= '0;
          iter_q  <= iter_nxt;
          if (term_now) begin
            termination_q <= 1'b1;
            state_q       <= StTerm;
          end else begin
            state_q <= StLayer;
          end
        end
        StTerm: begin
          if (!de_frame_start) begin
            frame_done_q  <= 1'b1;
            fsm_en_q      <= 1'b0;
            termination_q <= 1'b0;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign fsm_en       = fsm_en_q;
  assign layer_finish = layer_finish_q;
  assign termination  = termination_q;
  assign layer_idx    = layer_q;
  assign iter_idx     = iter_q;
  assign frame_done   = frame_done_q;
  assign early_term   = early_term_q;
  assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_ldpc_layer_scheduler.sv
// Scoreboard bench for ldpc_layer_scheduler; the bench plays host and CNU FSM.
module tb_ldpc_layer_scheduler;

  localparam int LN = 3;
  localparam int MI = 10;
  localparam int WB = 2;
`ifdef EARLY_TERM_EN
  localparam bit EarlyEn = 1'b1;
`else
  localparam bit EarlyEn = 1'b0;
`endif

  typedef struct {
    int cyc;
    int layer;
    int iter;
    int early;
  } exp_t;

  logic       read_clk = 1'b0;
  logic       rstn = 1'b0;
  logic       frame_valid = 1'b0;
  logic       frame_ready;
  logic       fsm_en;
  logic       de_frame_start = 1'b0;
  logic       c2v_mem_we = 1'b0;
  logic       layer_finish;
  logic       termination;
  logic [1:0] layer_idx;
  logic [3:0] iter_idx;
  logic       syndrome_valid = 1'b0;
  logic       syndrome_zero = 1'b0;
  logic       frame_done;
  logic       early_term;
  logic       proto_err;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   lf_cnt = 0;
  int   fd_cnt = 0;
  int   term_rises = 0;
  int   accepts = 0;
  bit   term_prev = 1'b0;
  exp_t lf_q[$];
  exp_t fd_q[$];

  ldpc_layer_scheduler #(
    .LAYER_NUM  (LN),
    .MAX_ITER   (MI),
    .WB_LATENCY (WB)
  ) dut (
    .read_clk       (read_clk),
    .rstn           (rstn),
    .frame_valid    (frame_valid),
    .frame_ready    (frame_ready),
    .fsm_en         (fsm_en),
    .de_frame_start (de_frame_start),
    .c2v_mem_we     (c2v_mem_we),
    .layer_finish   (layer_finish),
    .termination    (termination),
    .layer_idx      (layer_idx),
    .iter_idx       (iter_idx),
    .syndrome_valid (syndrome_valid),
    .syndrome_zero  (syndrome_zero),
    .frame_done     (frame_done),
    .early_term     (early_term),
    .proto_err      (proto_err)
  );

  always #5 read_clk = ~read_clk;
  always @(posedge read_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge read_clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a strobe.
  always @(negedge read_clk) begin
    exp_t e;
    if (!rstn) begin
      term_prev = 1'b0;
    end else begin
      if (frame_ready && frame_valid) accepts++;
      if (termination && !term_prev) term_rises++;
      term_prev = termination;
      if (layer_finish) begin
        lf_cnt++;
        if (lf_q.size() == 0) begin
          chk("lf_unexpected", 1, 0);
        end else begin
          e = lf_q.pop_front();
          chk("lf_cycle", cyc, e.cyc);
          chk("lf_layer", int'(layer_idx), e.layer);
          chk("lf_iter", int'(iter_idx), e.iter);
        end
      end
      if (frame_done) begin
        fd_cnt++;
        if (fd_q.size() == 0) begin
          chk("fd_unexpected", 1, 0);
        end else begin
          e = fd_q.pop_front();
          chk("fd_cycle", cyc, e.cyc);
          chk("fd_iter", int'(iter_idx), e.iter);
          chk("fd_early", int'(early_term), e.early);
          chk("fd_term_low", int'(termination), 0);
          chk("fd_fsm_en_low", int'(fsm_en), 0);
        end
      end
    end
  end

  // One layer: write-back strobe, optional stray strobe during the wait, wait for the commit.
  task automatic do_layer(input int l, input int it, input bit sv, input bit sz, input bit inj);
    exp_t e;
    int n;
    e.cyc   = cyc + WB + 1;
    e.layer = (l < LN - 1) ? l + 1 : l;
    e.iter  = it;
    e.early = 0;
    lf_q.push_back(e);
    c2v_mem_we = 1'b1;
    syndrome_valid = sv;
    syndrome_zero = sz;
    tick();
    c2v_mem_we = 1'b0;
    syndrome_valid = 1'b0;
    syndrome_zero = 1'b0;
    if (inj) begin
      c2v_mem_we = 1'b1;
      tick();
      c2v_mem_we = 1'b0;
      chk("proto_err_set", int'(proto_err), 1);
    end
    n = 0;
    while (!layer_finish && n < 16) begin
      tick();
      n++;
    end
    chk("lf_seen", int'(layer_finish), 1);
    tick();
  endtask

  task automatic run_frame(input int synd_it, input int nz_it, input int inj_it,
                           input int abort_it, input bit hold);
    bit   stop;
    exp_t e;
    frame_valid = 1'b1;
    chk("idle_ready", int'(frame_ready), 1);
    chk("idle_fsm_en", int'(fsm_en), 0);
    tick();
    if (!hold) frame_valid = 1'b0;
    chk("fsm_en_rise", int'(fsm_en), 1);
    chk("busy_ready", int'(frame_ready), 0);
    chk("accept_layer", int'(layer_idx), 0);
    chk("accept_iter", int'(iter_idx), 0);
    chk("accept_early_clr", int'(early_term), 0);
    de_frame_start = 1'b1;
    tick();
    for (int it = 0; it < MI; it++) begin
      for (int l = 0; l < LN; l++) begin
        if (it == abort_it && l == 1) begin
          chk("pre_abort_iter", int'(iter_idx), it);
          if (inj_it >= 0) chk("proto_err_sticky", int'(proto_err), 1);
          c2v_mem_we = 1'b1;
          tick();
          c2v_mem_we = 1'b0;
          #2 rstn = 1'b0;
          #1;
          chk("abort_fsm_en", int'(fsm_en), 0);
          chk("abort_layer", int'(layer_idx), 0);
          chk("abort_iter", int'(iter_idx), 0);
          chk("abort_ready", int'(frame_ready), 1);
          chk("abort_proto_err", int'(proto_err), 0);
          lf_q.delete();
          fd_q.delete();
          de_frame_start = 1'b0;
          frame_valid = 1'b0;
          @(posedge read_clk);
          #1 rstn = 1'b1;
          tick();
          return;
        end
        do_layer(l, it, (l == 0) && (it == synd_it || it == nz_it), (l == 0) && (it == synd_it),
                 (l == 0) && (it == inj_it));
      end
      stop = (it + 1 == MI) || (EarlyEn && it == synd_it);
      chk("term_at_iter_end", int'(termination), int'(stop));
      chk("iter_after_chk", int'(iter_idx), it + 1);
      chk("layer_wrap", int'(layer_idx), 0);
      if (stop) begin
        de_frame_start = 1'b0;
        e.cyc   = cyc + 1;
        e.layer = 0;
        e.iter  = it + 1;
        e.early = int'(EarlyEn && it == synd_it && it + 1 < MI);
        fd_q.push_back(e);
        tick();
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge read_clk);
    #1;
    chk("rst_ready", int'(frame_ready), 1);
    chk("rst_fsm_en", int'(fsm_en), 0);
    chk("rst_layer_finish", int'(layer_finish), 0);
    chk("rst_termination", int'(termination), 0);
    chk("rst_layer", int'(layer_idx), 0);
    chk("rst_iter", int'(iter_idx), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_early", int'(early_term), 0);
    chk("rst_proto_err", int'(proto_err), 0);
    rstn = 1'b1;
    tick();

    // Frame A: plain full-length frame.
    lf_cnt = 0; fd_cnt = 0; term_rises = 0;
    run_frame(-1, -1, -1, -1, 1'b0);
    tick();
    chk("a_lf_count", lf_cnt, LN * MI);
    chk("a_term_rises", term_rises, 1);
    chk("a_fd_count", fd_cnt, 1);
    chk("a_iter_final", int'(iter_idx), MI);
    chk("a_early", int'(early_term), 0);
    chk("a_ready", int'(frame_ready), 1);

    // Frame B: non-zero syndrome in iteration 1, zero syndrome in iteration 2.
    run_frame(2, 1, -1, -1, 1'b0);
    repeat (4) tick();
    chk("b_early_hold", int'(early_term), int'(EarlyEn));
    chk("b_iter_final", int'(iter_idx), EarlyEn ? 3 : MI);
    chk("b_proto_clean", int'(proto_err), 0);

    // Frame C: stray write-back strobe, then reset mid-frame in iteration 5.
    run_frame(-1, -1, 0, 5, 1'b0);
    chk("c_ready_after_rst", int'(frame_ready), 1);

    // Frame D: frame_valid held through the whole frame.
    accepts = 0;
    fd_cnt = 0;
    run_frame(-1, -1, -1, -1, 1'b1);
    chk("d_single_accept", accepts, 1);
    chk("d_fd_ready", int'(frame_ready), 1);
    tick();
    chk("d_second_accept", accepts, 2);
    chk("d_refill_fsm_en", int'(fsm_en), 1);
    chk("d_fd_count", fd_cnt, 1);
    frame_valid = 1'b0;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();

    chk("lf_queue_empty", lf_q.size(), 0);
    chk("fd_queue_empty", fd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
